therm14_gen: RTL and testbench
==============================

# therm14_gen

Binary-to-thermometer stimulus generator for the 14-comparator flash bank. It accepts 4-bit codes over a valid/ready handshake and drives the matching 14-bit thermometer word, registered, for a programmable number of cycles. It feeds the comparator-bank model and the downstream thermometer encoder in loopback/self-test. The mapping is the exact inverse of the encoder, including saturation of out-of-range codes to 13.

## Interface
- `HOLD_W`, default 8: width of the hold-length input and the internal hold counter.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `code_i`  in  4: binary code to convert.
- `code_valid_i`  in  1: `code_i` and `hold_i` are valid.
- `code_ready_o`  out  1: block can accept a code this cycle.
- `hold_i`  in  HOLD_W: number of cycles to present the word; 0 is treated as 1. Sampled at acceptance.
- `therm_o`  out  14: registered thermometer word.
- `therm_valid_o`  out  1: `therm_o` holds a live code.
- `sat_o`  out  1: one-cycle pulse when the presented code was saturated.
- `inj_en_i`  in  1: only with `THERM14_BUBBLE_INJ_EN`; inject a bubble into this code.
- `inj_pos_i`  in  4: only with `THERM14_BUBBLE_INJ_EN`; bit index to invert.

## Operation
- **Acceptance:** occurs on a rising edge where `code_valid_i & code_ready_o`.
- **Mapping:** code k in 0..13 gives `therm_o = (1<<k)-1`.
  - Examples: 0 → 14'h0000, 1 → 14'h0001, 13 → 14'h1FFF.
  - Codes 14 and 15 saturate to 14'h1FFF and assert `sat_o`.
- **State machine:**
  - IDLE → HOLD on acceptance. The hold counter loads `max(hold_i,1)-1`.
  - HOLD with counter > 0: decrement.
  - HOLD with counter == 0: if acceptance occurs this cycle, reload with the new code and stay in HOLD. Otherwise go to IDLE.
- **Ready:** `code_ready_o = rst_n & (state==IDLE | counter==0)`. This is combinational from state and counter, and allows back-to-back codes with no gap.
- **Outputs by state:**
  - `therm_valid_o` is 1 in HOLD and 0 in IDLE.
  - In IDLE, `therm_o` keeps the last presented word (it is not cleared).
- **`sat_o`:** high only on the first output cycle of a saturated code, and never on the remaining hold cycles.
- **Input stability:** `code_i` and `hold_i` changes outside acceptance are ignored.
- **Reset mid-operation:** any `rst_n` low edge forces IDLE, counter 0, and clears all outputs. Any in-progress hold is discarded.

## Timing
- **Reset values:** `therm_o`=14'h0000, `therm_valid_o`=0, `sat_o`=0, `code_ready_o`=0 while `rst_n`=0. `code_ready_o` is 1 on the first cycle after release.
- **Latency:** acceptance at edge N means `therm_o`, `therm_valid_o` and `sat_o` update at edge N+1.
- **Hold window:** the word stays valid for exactly `max(hold_i,1)` cycles.
- **Back-to-back:** acceptance on the last hold cycle replaces the word at the next edge. `therm_valid_o` stays high with no bubble cycle.
- **Throughput:** one code per cycle when `hold_i` ≤ 1 and `code_valid_i` is held high.

## Configuration
- **Macro `THERM14_BUBBLE_INJ_EN` defined:**
  - Ports `inj_en_i` and `inj_pos_i` exist and are sampled at acceptance.
  - If `inj_en_i`=1 and `inj_pos_i` ≤ 13, bit `inj_pos_i` of the mapped word is inverted for that code's whole hold window.
  - If `inj_pos_i` > 13, no inversion occurs.
  - Injection is applied after saturation.
- **Macro not defined:** the ports are absent, no inversion logic is built, and the output is always a clean thermometer word.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release. While `rst_n`=0: `therm_o`=0, `therm_valid_o`=0, `sat_o`=0 and `code_ready_o`=0. `code_ready_o`=1 on the cycle after release.
- **Sweep:** `code_i`=0..15 back-to-back with `hold_i`=1 and valid held high.
  - Each word appears one cycle after acceptance and equals `(1<<k)-1`.
  - Codes 14 and 15 give 14'h1FFF with `sat_o`=1 for exactly one cycle.
  - `therm_valid_o` stays high with no gap.
- **Hold:** `code_i`=5, `hold_i`=4.
  - 14'h001F is valid for exactly 4 cycles and `code_ready_o` is low for the first 3.
  - `hold_i`=0 gives a 1-cycle window.
- **Idle retention:** after code 9 with `hold_i`=2 and no further valid, `therm_valid_o` drops and `therm_o` stays 14'h01FF.
- **Reset mid-hold:** `code_i`=7 with `hold_i`=10, then pull `rst_n` low on the 3rd hold cycle. Outputs are 0 at the next edge, and the old code is not resumed after release.
- **With `THERM14_BUBBLE_INJ_EN`:**
  - `code_i`=6, `inj_en_i`=1, `inj_pos_i`=2 → 14'h003B for the whole window.
  - `inj_pos_i`=14 → 14'h003F.
  - `code_i`=15, `inj_pos_i`=0 → 14'h1FFE with `sat_o`=1.

Source files
------------

// File: rtl/therm14_gen_if.sv
// therm14_gen_if: code handshake and thermometer output bundle for therm14_gen.
// THERM14_BUBBLE_INJ_EN adds the bubble-injection fields to the code side.
interface therm14_gen_if #(parameter int HOLD_W = 8);
    logic [3:0]        code_i;
    logic              code_valid_i;
    logic              code_ready_o;
    logic [HOLD_W-1:0] hold_i;
    logic [13:0]       therm_o;
    logic              therm_valid_o;
    logic              sat_o;
`ifdef THERM14_BUBBLE_INJ_EN
    logic              inj_en_i;
    logic [3:0]        inj_pos_i;
    modport master (output code_i, code_valid_i, hold_i, inj_en_i, inj_pos_i,
                    input code_ready_o, therm_o, therm_valid_o, sat_o);
    modport slave (input code_i, code_valid_i, hold_i, inj_en_i, inj_pos_i,
                   output code_ready_o, therm_o, therm_valid_o, sat_o);
`else
    modport master (output code_i, code_valid_i, hold_i,
                    input code_ready_o, therm_o, therm_valid_o, sat_o);
    modport slave (input code_i, code_valid_i, hold_i,
                   output code_ready_o, therm_o, therm_valid_o, sat_o);
`endif
endinterface

// File: rtl/therm14_gen.sv
// therm14_gen: 4-bit code to registered 14-bit thermometer word, held for a programmable window.
// THERM14_BUBBLE_INJ_EN builds optional single-bit bubble injection into the presented word.
module therm14_gen #(
    parameter int HOLD_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    therm14_gen_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t            state, state_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [13:0]       therm, word, word_inj;
    logic              sat, sat_word, acc;
    always_comb begin
        sat_word = bus.code_i > 4'd13;
        word     = sat_word ? 14'h1FFF : (14'd1 << bus.code_i) - 14'd1;
`ifdef THERM14_BUBBLE_INJ_EN
        // bubble goes in after saturation so saturated words can be corrupted too
        word_inj = word ^ ((bus.inj_en_i && bus.inj_pos_i <= 4'd13) ? (14'd1 << bus.inj_pos_i) : 14'd0);
`else
        word_inj = word;
`endif
    end
    assign bus.code_ready_o  = rst_n & (state == IDLE | cnt == '0);
    assign acc               = bus.code_valid_i & bus.code_ready_o;
    assign bus.therm_o       = therm;
    assign bus.therm_valid_o = state == HOLD;
    assign bus.sat_o         = sat;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (acc) begin
            state_nxt = HOLD;
            cnt_nxt   = (bus.hold_i == '0) ? '0 : bus.hold_i - HOLD_W'(1);
        end else if (state == HOLD && cnt != '0)
            cnt_nxt = cnt - HOLD_W'(1);
        else
            state_nxt = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            therm <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (acc) therm <= word_inj;
            sat   <= acc & sat_word;
        end
    end
endmodule

// File: tb/tb_therm14_gen.sv
// tb_therm14_gen: directed self-checking bench for therm14_gen.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_therm14_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    therm14_gen_if #(.HOLD_W(8)) bus ();
    therm14_gen #(.HOLD_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.code_valid_i = 1'b0;
        bus.code_i = 4'd0;
        bus.hold_i = 8'd1;
`ifdef THERM14_BUBBLE_INJ_EN
        bus.inj_en_i = 1'b0;
        bus.inj_pos_i = 4'd0;
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.therm_o !== 14'h0000) begin n_bad++; $display("FAIL reset_therm cyc=%0d got %h exp 0000", i, bus.therm_o); end
            n_cmp++; if (bus.therm_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid cyc=%0d got %b exp 0", i, bus.therm_valid_o); end
            n_cmp++; if (bus.sat_o !== 1'b0) begin n_bad++; $display("FAIL reset_sat cyc=%0d got %b exp 0", i, bus.sat_o); end
            n_cmp++; if (bus.code_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready cyc=%0d got %b exp 0", i, bus.code_ready_o); end
        end
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.code_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready_release got %b exp 1", bus.code_ready_o); end
        n_cmp++; if (bus.therm_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid_release got %b exp 0", bus.therm_valid_o); end
    endtask

    task automatic test_sweep();
        logic [13:0] exp_w [16] = '{14'h0000, 14'h0001, 14'h0003, 14'h0007, 14'h000F, 14'h001F, 14'h003F, 14'h007F,
                                    14'h00FF, 14'h01FF, 14'h03FF, 14'h07FF, 14'h0FFF, 14'h1FFF, 14'h1FFF, 14'h1FFF};
        bus.code_valid_i = 1'b1;
        bus.hold_i = 8'd1;
        bus.code_i = 4'd0;
        for (int k = 0; k < 16; k++) begin
            step();
            n_cmp++; if (bus.therm_o !== exp_w[k]) begin n_bad++; $display("FAIL sweep_therm code=%0d got %h exp %h", k, bus.therm_o, exp_w[k]); end
            n_cmp++; if (bus.therm_valid_o !== 1'b1) begin n_bad++; $display("FAIL sweep_valid code=%0d got %b exp 1", k, bus.therm_valid_o); end
            n_cmp++; if (bus.sat_o !== (k >= 14)) begin n_bad++; $display("FAIL sweep_sat code=%0d got %b exp %b", k, bus.sat_o, k >= 14); end
            n_cmp++; if (bus.code_ready_o !== 1'b1) begin n_bad++; $display("FAIL sweep_ready code=%0d got %b exp 1", k, bus.code_ready_o); end
            bus.code_i = 4'(k + 1);
        end
        bus.code_valid_i = 1'b0;
        step();
        n_cmp++; if (bus.therm_valid_o !== 1'b0) begin n_bad++; $display("FAIL sweep_end_valid got %b exp 0", bus.therm_valid_o); end
        n_cmp++; if (bus.sat_o !== 1'b0) begin n_bad++; $display("FAIL sweep_end_sat got %b exp 0", bus.sat_o); end
        n_cmp++; if (bus.therm_o !== 14'h1FFF) begin n_bad++; $display("FAIL sweep_end_therm got %h exp 1fff", bus.therm_o); end
    endtask

    task automatic test_hold();
        bus.code_i = 4'd5;
        bus.hold_i = 8'd4;
        bus.code_valid_i = 1'b1;
        step();
        bus.code_valid_i = 1'b0;
        bus.code_i = 4'd2;
        bus.hold_i = 8'd7;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_cmp++; if (bus.therm_o !== 14'h001F) begin n_bad++; $display("FAIL hold_therm cyc=%0d got %h exp 001f", i, bus.therm_o); end
            n_cmp++; if (bus.therm_valid_o !== 1'b1) begin n_bad++; $display("FAIL hold_valid cyc=%0d got %b exp 1", i, bus.therm_valid_o); end
            n_cmp++; if (bus.code_ready_o !== (i == 3)) begin n_bad++; $display("FAIL hold_ready cyc=%0d got %b exp %b", i, bus.code_ready_o, i == 3); end
        end
        step();
        n_cmp++; if (bus.therm_valid_o !== 1'b0) begin n_bad++; $display("FAIL hold_end_valid got %b exp 0", bus.therm_valid_o); end
        bus.code_i = 4'd3;
        bus.hold_i = 8'd0;
        bus.code_valid_i = 1'b1;
        step();
        bus.code_valid_i = 1'b0;
        n_cmp++; if (bus.therm_o !== 14'h0007) begin n_bad++; $display("FAIL hold0_therm got %h exp 0007", bus.therm_o); end
        n_cmp++; if (bus.therm_valid_o !== 1'b1) begin n_bad++; $display("FAIL hold0_valid got %b exp 1", bus.therm_valid_o); end
        n_cmp++; if (bus.code_ready_o !== 1'b1) begin n_bad++; $display("FAIL hold0_ready got %b exp 1", bus.code_ready_o); end
        step();
        n_cmp++; if (bus.therm_valid_o !== 1'b0) begin n_bad++; $display("FAIL hold0_end_valid got %b exp 0", bus.therm_valid_o); end
    endtask

    task automatic test_idle_retention();
        bus.code_i = 4'd9;
        bus.hold_i = 8'd2;
        bus.code_valid_i = 1'b1;
        step();
        bus.code_valid_i = 1'b0;
        bus.code_i = 4'd1;
        step();
        n_cmp++; if (bus.therm_valid_o !== 1'b1) begin n_bad++; $display("FAIL idle_valid_cyc2 got %b exp 1", bus.therm_valid_o); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.therm_valid_o !== 1'b0) begin n_bad++; $display("FAIL idle_valid cyc=%0d got %b exp 0", i, bus.therm_valid_o); end
            n_cmp++; if (bus.therm_o !== 14'h01FF) begin n_bad++; $display("FAIL idle_therm cyc=%0d got %h exp 01ff", i, bus.therm_o); end
        end
    endtask

    task automatic test_reset_mid_hold();
        bus.code_i = 4'd7;
        bus.hold_i = 8'd10;
        bus.code_valid_i = 1'b1;
        step();
        bus.code_valid_i = 1'b0;
        step();
        step();
        n_cmp++; if (bus.therm_o !== 14'h007F) begin n_bad++; $display("FAIL midrst_pre_therm got %h exp 007f", bus.therm_o); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.code_ready_o !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got %b exp 0", bus.code_ready_o); end
        step();
        n_cmp++; if (bus.therm_o !== 14'h0000) begin n_bad++; $display("FAIL midrst_therm got %h exp 0000", bus.therm_o); end
        n_cmp++; if (bus.therm_valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b exp 0", bus.therm_valid_o); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.therm_valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_resume_valid cyc=%0d got %b exp 0", i, bus.therm_valid_o); end
            n_cmp++; if (bus.therm_o !== 14'h0000) begin n_bad++; $display("FAIL midrst_resume_therm cyc=%0d got %h exp 0000", i, bus.therm_o); end
        end
    endtask

`ifdef THERM14_BUBBLE_INJ_EN
    task automatic test_inject();
        bus.code_i = 4'd6;
        bus.hold_i = 8'd3;
        bus.inj_en_i = 1'b1;
        bus.inj_pos_i = 4'd2;
        bus.code_valid_i = 1'b1;
        step();
        bus.code_valid_i = 1'b0;
        bus.inj_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            n_cmp++; if (bus.therm_o !== 14'h003B) begin n_bad++; $display("FAIL inj_therm cyc=%0d got %h exp 003b", i, bus.therm_o); end
        end
        bus.inj_en_i = 1'b1;
        bus.inj_pos_i = 4'd14;
        bus.hold_i = 8'd1;
        bus.code_valid_i = 1'b1;
        step();
        n_cmp++; if (bus.therm_o !== 14'h003F) begin n_bad++; $display("FAIL inj_pos14_therm got %h exp 003f", bus.therm_o); end
        bus.code_i = 4'd15;
        bus.inj_pos_i = 4'd0;
        step();
        bus.code_valid_i = 1'b0;
        bus.inj_en_i = 1'b0;
        n_cmp++; if (bus.therm_o !== 14'h1FFE) begin n_bad++; $display("FAIL inj_sat_therm got %h exp 1ffe", bus.therm_o); end
        n_cmp++; if (bus.sat_o !== 1'b1) begin n_bad++; $display("FAIL inj_sat_sat got %b exp 1", bus.sat_o); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_hold();
        test_idle_retention();
        test_reset_mid_hold();
`ifdef THERM14_BUBBLE_INJ_EN
        test_inject();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
